// File: rtl/secded_decoder.sv
// rtl/secded_decoder.sv - SEC-DED decoder for Small/Medium/Large codewords with two-stage valid/ready pipeline
module secded_decoder #(
  parameter int AMBA_WORD = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AMBA_WORD-1:0] data_in,
  input  logic [1:0]           code_width,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AMBA_WORD-1:0] data_out,
  output logic [1:0]           num_of_errors,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Parity mask k covers the data bits feeding syndrome bit k (frame position base+k).
  function automatic logic [31:0] pmask(input logic [1:0] w, input int k);
    logic [31:0] m;
    m = '0;
    case (w)
      2'b00: case (k)
        0: m = 32'hB000_0000;
        1: m = 32'hD000_0000;
        2: m = 32'hE000_0000;
        3: m = 32'h7000_0000;
        default: m = '0;
      endcase
      2'b01: case (k)
        0: m = 32'hAB60_0000;
        1: m = 32'hCDA0_0000;
        2: m = 32'hF1C0_0000;
        3: m = 32'hFE00_0000;
        4: m = 32'h96E0_0000;
        default: m = '0;
      endcase
      2'b10: case (k)
        0: m = 32'hAAAB_56C0;
        1: m = 32'hCCCD_9B40;
        2: m = 32'hF0F1_E380;
        3: m = 32'hFF01_FC00;
        4: m = 32'hFFFE_0000;
        5: m = 32'h6997_2DC0;
        default: m = '0;
      endcase
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic int n_par(input logic [1:0] w);
    case (w)
      2'b00:   return 4;
      2'b01:   return 5;
      2'b10:   return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int par_base(input logic [1:0] w);
    case (w)
      2'b00:   return 24;
      2'b01:   return 16;
      default: return 0;
    endcase
  endfunction

  // Syndrome column of frame bit b: mask membership for data bits, unit vector for parity bits.
  function automatic logic [5:0] column(input logic [1:0] w, input int b);
    logic [5:0]  c;
    logic [31:0] m;
    c = '0;
    m = '0;
    for (int k = 0; k < 6; k++) begin
      if (k < n_par(w)) begin
        m    = pmask(w, k);
        c[k] = m[b] | (b == par_base(w) + k);
      end
    end
    return c;
  endfunction

  logic        advance;
  logic [31:0] frame_in;
  logic [5:0]  syn_in;

  logic        s1_valid;
  logic [31:0] s1_frame;
  logic [1:0]  s1_width;
  logic [5:0]  s1_syn;

  logic [31:0]          flip;
  logic [31:0]          corrected;
  logic [AMBA_WORD-1:0] dec_data;
  logic [1:0]           dec_err;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    frame_in = '0;
    case (code_width)
      2'b00:   frame_in = {data_in[7:0], 24'h0};
      2'b01:   frame_in = {data_in[15:0], 16'h0};
      2'b10:   frame_in = data_in;
      default: frame_in = '0;
    endcase
    syn_in = '0;
    for (int k = 0; k < 6; k++) begin
      if (k < n_par(code_width))
        syn_in[k] = frame_in[par_base(code_width) + k] ^ (^(frame_in & pmask(code_width, k)));
    end
  end

  always_comb begin
    flip = '0;
    for (int b = 0; b < 32; b++)
      flip[b] = (s1_syn != 6'd0) && (s1_syn == column(s1_width, b));
    corrected = s1_frame ^ flip;

    dec_data = '0;
    case (s1_width)
      2'b00:   dec_data = {28'h0, corrected[31:28]};
      2'b01:   dec_data = {21'h0, corrected[31:21]};
      2'b10:   dec_data = {6'h0, corrected[31:6]};
      default: dec_data = '0;
    endcase

    dec_err = 2'b00;
    if (s1_width == 2'b11)
      dec_err = 2'b11;
    else if (s1_syn == 6'd0)
      dec_err = 2'b00;
    else if (|flip)
      dec_err = 2'b01;
    else
      dec_err = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_frame      <= '0;
      s1_width      <= 2'b00;
      s1_syn        <= '0;
      out_valid     <= 1'b0;
      data_out      <= '0;
      num_of_errors <= 2'b00;
    end else if (advance) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_frame <= frame_in;
        s1_width <= code_width;
        s1_syn   <= syn_in;
      end
      if (s1_valid) begin
        data_out      <= dec_data;
        num_of_errors <= dec_err;
      end
    end
  end

  // Clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (num_of_errors == 2'b01 && corr_cnt != CNT_MAX)
        corr_cnt <= corr_cnt + CNT_W'(1);
      if (num_of_errors == 2'b10 && uncorr_cnt != CNT_MAX)
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_secded_decoder.sv
// tb/tb_secded_decoder.sv - directed self-checking bench for secded_decoder
module tb_secded_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [1:0]  code_width;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        cnt_clr;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secded_decoder #(.AMBA_WORD(32), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .code_width(code_width),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .num_of_errors(num_of_errors),
    .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One isolated word: latency counted in cycles from the cycle in_valid is presented.
  task automatic xfer(input string tag, input logic [31:0] d, input logic [1:0] w,
                      input logic [31:0] exp_d, input logic [1:0] exp_e, input logic clr);
    int cyc;
    @(negedge clk);
    data_in = d; code_width = w; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd2);
    check({tag, "_data"}, data_out, exp_d);
    check({tag, "_err"}, 32'(num_of_errors), 32'(exp_e));
    cnt_clr = clr;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  logic [31:0] bp_d  [4] = '{32'h0000_00B1, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0071};
  logic [1:0]  bp_w  [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
  logic [31:0] bp_xd [4] = '{32'hB, 32'h7FF, 32'h0, 32'h7};
  logic [1:0]  bp_xe [4] = '{2'b00, 2'b00, 2'b00, 2'b10};

  initial begin
    int sent, recv, extra;
    logic saw_low, prev_stall;
    logic [31:0] prev_d;
    logic [1:0]  prev_e;

    rst = 1'b1; in_valid = 1'b0; data_in = '0; code_width = 2'b00;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_data", data_out, 32'd0);
    check("rst_err", 32'(num_of_errors), 32'd0);
    check("rst_corr", 32'(corr_cnt), 32'd0);
    check("rst_uncorr", 32'(uncorr_cnt), 32'd0);

    xfer("s_clean", 32'h0000_00B1, 2'b00, 32'hB, 2'b00, 1'b0);
    xfer("s_dbit", 32'h0000_0031, 2'b00, 32'hB, 2'b01, 1'b0);
    xfer("s_pbit", 32'h0000_00B0, 2'b00, 32'hB, 2'b01, 1'b0);
    check("s_corr_cnt", 32'(corr_cnt), 32'd2);
    xfer("s_double", 32'h0000_0071, 2'b00, 32'h7, 2'b10, 1'b0);
    check("s_uncorr_cnt", 32'(uncorr_cnt), 32'd1);
    xfer("m_clean", 32'h0000_FFFF, 2'b01, 32'h7FF, 2'b00, 1'b0);
    xfer("m_pbit", 32'h0000_FFFE, 2'b01, 32'h7FF, 2'b01, 1'b0);
    xfer("l_clean", 32'h0000_0000, 2'b10, 32'h0, 2'b00, 1'b0);
    xfer("l_single", 32'h8000_0000, 2'b10, 32'h0, 2'b01, 1'b0);
    xfer("l_double", 32'hC000_0000, 2'b10, 32'h0300_0000, 2'b10, 1'b0);
    xfer("reserved", 32'hFFFF_FFFF, 2'b11, 32'h0, 2'b11, 1'b0);
    check("res_corr_cnt", 32'(corr_cnt), 32'd4);
    check("res_uncorr_cnt", 32'(uncorr_cnt), 32'd2);

    // Backpressure: out_ready low for cycles 3..5 of the stream.
    sent = 0; recv = 0; extra = 0; saw_low = 1'b0; prev_stall = 1'b0;
    prev_d = '0; prev_e = 2'b00;
    for (int t = 0; t < 40 && recv < 4; t++) begin
      @(negedge clk);
      out_ready = !(t >= 3 && t < 6);
      if (sent < 4) begin
        in_valid = 1'b1; data_in = bp_d[sent]; code_width = bp_w[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check("bp_hold_data", data_out, prev_d);
        check("bp_hold_err", 32'(num_of_errors), 32'(prev_e));
      end
      if (out_valid && out_ready) begin
        check("bp_data", data_out, bp_xd[recv]);
        check("bp_err", 32'(num_of_errors), 32'(bp_xe[recv]));
        recv++;
      end
      if (!in_ready) saw_low = 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_d = data_out; prev_e = num_of_errors;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (out_valid) extra++;
    end
    check("bp_recv", 32'(recv), 32'd4);
    check("bp_extra", 32'(extra), 32'd0);
    check("bp_in_ready_low", 32'(saw_low), 32'd1);
    check("pre_rst_corr", 32'(corr_cnt), 32'd4);
    check("pre_rst_uncorr", 32'(uncorr_cnt), 32'd3);

    // Reset with both stages full.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; data_in = 32'h31; code_width = 2'b00;
    repeat (3) @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_corr", 32'(corr_cnt), 32'd0);
    check("mid_rst_uncorr", 32'(uncorr_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Clear coinciding with a corrected-word handshake.
    xfer("clr_a", 32'h31, 2'b00, 32'hB, 2'b01, 1'b0);
    check("clr_a_corr", 32'(corr_cnt), 32'd1);
    xfer("clr_b", 32'h31, 2'b00, 32'hB, 2'b01, 1'b1);
    check("clr_b_corr", 32'(corr_cnt), 32'd0);

    // Saturation: exactly 65535 corrected words, then one more.
    @(negedge clk);
    data_in = 32'h31; code_width = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    repeat (65535) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_reach", 32'(corr_cnt), 32'h0000_FFFF);
    xfer("sat_more", 32'h31, 2'b00, 32'hB, 2'b01, 1'b0);
    check("sat_hold", 32'(corr_cnt), 32'h0000_FFFF);
    check("sat_uncorr", 32'(uncorr_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
